// File: rtl/ahb3lite_mem_slave_ctrl.sv
// ahb3lite_mem_slave_ctrl
//   AHB3-Lite slave front end for a word-addressed backing memory. It accepts
//   address phases, optionally inserts wait states, and then drives the
//   memory read/write strobes for one data-phase cycle. It returns read data
//   combinationally from the memory and raises a two-cycle ERROR response for
//   illegal transfers.
//
// Parameters
//   MEM_DEPTH   : number of 32-bit words in the backing memory (power of 2)
//   WAIT_STATES : wait cycles inserted before every valid data phase (0..15)
//
// Ports
//   HCLK, HRESETn            : bus clock, asynchronous active-low reset
//   HSEL, HADDR, HWRITE,
//   HTRANS, HSIZE, HREADY    : AHB address-phase inputs
//   HWDATA                   : AHB write data (data phase)
//   HREADYOUT, HRESP, HRDATA : AHB slave response
//   mem_read_flag/addr       : memory read strobe and word index
//   mem_rdata                : combinational read data from memory
//   mem_write_flag/addr      : memory write strobe and word index
//   mem_wdata                : write data to memory
module ahb3lite_mem_slave_ctrl #(
  parameter int unsigned MEM_DEPTH   = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        mem_read_flag,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_write_flag,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_wdata
);

  localparam int unsigned AW      = $clog2(MEM_DEPTH);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] rd_hold_q, wr_hold_q;
  logic          ready_now;
  logic          accept;
  logic          req_err;

  // A new address phase can only be taken while this slave shows ready.
  assign ready_now = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept    = HSEL && HREADY && ready_now &&
                     ((HTRANS == 2'b10) || (HTRANS == 2'b11));

  // Any address bit at or above the array range is an error; no wrap-around.
  assign req_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) ||
                   ((HADDR >> (AW + 2)) != '0);

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_DATA;
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept)               state_d = ST_IDLE;
        else if (req_err)          state_d = ST_ERR1;
        else if (WAIT_STATES == 0) state_d = ST_DATA;
        else                       state_d = ST_WAIT;
      end
    endcase
  end

  // Captured transfer attributes, wait counter, and held strobe addresses
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_q     <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      rd_hold_q <= '0;
      wr_hold_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= HADDR[AW+1:2];
        wr_q  <= HWRITE;
      end
      if ((state_d == ST_WAIT) && (state_q != ST_WAIT))
        cnt_q <= WS_LOAD;
      else if ((state_q == ST_WAIT) && (cnt_q != 4'd0))
        cnt_q <= cnt_q - 4'd1;
      // Addresses are shown live during DATA and held afterwards.
      if (state_q == ST_DATA) begin
        if (wr_q) wr_hold_q <= idx_q;
        else      rd_hold_q <= idx_q;
      end
    end
  end

  // Output logic: decoded from the state so reset clears strobes at once
  always_comb begin
    HREADYOUT      = 1'b1;
    HRESP          = 1'b0;
    HRDATA         = '0;
    mem_read_flag  = 1'b0;
    mem_write_flag = 1'b0;
    mem_read_addr  = 32'(rd_hold_q);
    mem_write_addr = 32'(wr_hold_q);
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: begin
        if (wr_q) begin
          mem_write_flag = 1'b1;
          mem_write_addr = 32'(idx_q);
        end else begin
          mem_read_flag = 1'b1;
          mem_read_addr = 32'(idx_q);
          HRDATA        = mem_rdata;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  assign mem_wdata = HWDATA;

endmodule
